// File: rtl/vga_text_pkg.sv
// Shared constants, pipeline stage records and colour palette for the text renderer.
package vga_text_pkg;

    localparam int COLS      = 80;
    localparam int ROWS      = 60;

    // Cell word layout: [6:0] char, [7] blink, [11:8] fg, [15:12] bg
    localparam int CHAR_LSB  = 0;
    localparam int CHAR_MSB  = 6;
    localparam int BLINK_BIT = 7;
    localparam int FG_LSB    = 8;
    localparam int BG_LSB    = 12;

    // Fields carried from S1 to S2
    typedef struct packed {
        logic [2:0] px;
        logic [2:0] py;
        logic       von;
        logic       hs;
        logic       vs;
        logic       cur;
    } s1_t;

    // Fields carried from S2 to S3
    typedef struct packed {
        logic       dot;
        logic [3:0] fg;
        logic [3:0] bg;
        logic       blk;
        logic       cur7;
        logic       von;
        logic       hs;
        logic       vs;
    } s2_t;

    // Idle sync level: high when syncs are active-low
    function automatic logic sync_idle(input logic active_low);
        return active_low;
    endfunction

    // idx[3] = intensity (F vs A), idx[2:0] = R,G,B enables; 8 is dark grey
    function automatic logic [11:0] palette(input logic [3:0] idx);
        logic [3:0] lvl;
        lvl = idx[3] ? 4'hF : 4'hA;
        if (idx == 4'h8)
            return 12'h555;
        return {idx[2] ? lvl : 4'h0, idx[1] ? lvl : 4'h0, idx[0] ? lvl : 4'h0};
    endfunction

endpackage

// File: rtl/vga_blink_timer.sv
// Counts vsync assertions and toggles the blink phase every BLINK_FRAMES frames.
module vga_blink_timer #(
    parameter int BLINK_FRAMES    = 30,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync_in,
    output logic blink_phase
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] frame_cnt;
    logic          vs_act;
    logic          vs_act_q;
    logic          vs_rise;

    assign vs_act  = vsync_in ^ SYNC_ACTIVE_LOW;
    assign vs_rise = vs_act & ~vs_act_q;

    // Edge detect on the active sync level, count frames, toggle phase at wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_act_q    <= 1'b0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            vs_act_q <= vs_act;
            if (vs_rise) begin
                if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_text_render.sv
// Three-stage character-mode pixel pipeline: cell fetch, font lookup, colour out.
module vga_text_render
    import vga_text_pkg::*;
#(
    parameter int BLINK_FRAMES    = 30,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [12:0] text_addr,
    input  logic [15:0] text_data,
    output logic [9:0]  font_addr,
    input  logic [7:0]  font_row,
    input  logic [6:0]  cur_x,
    input  logic [5:0]  cur_y,
    input  logic        cur_en,
    output logic [11:0] rgb,
    output logic        hsync,
    output logic        vsync
);

    localparam logic SYNC_IDLE = sync_idle(SYNC_ACTIVE_LOW);

    logic [6:0]  ccol;
    logic [5:0]  crow;
    logic [12:0] cell_addr;
    logic        cur_hit;
    logic        blink_phase;
    logic        on;
    logic        unused_vmsb;
    logic [1:0]  vld_pipe;
    s1_t         s1;
    s2_t         s2;

    // Only 480 visible lines, so the top line bit never selects a cell row
    assign unused_vmsb = v_cnt[9];

    assign ccol      = h_cnt[9:3];
    assign crow      = v_cnt[8:3];
    // Constant multiply by COLS reduces to shift-add; max 59*80+79 fits 13 bits
    assign cell_addr = 13'(crow) * 13'(COLS) + 13'(ccol);
    // Out-of-range cursor positions are suppressed so blanking columns never match
    assign cur_hit   = cur_en && (cur_x < 7'(COLS)) && (cur_y < 6'(ROWS)) &&
                       (ccol == cur_x) && (crow == cur_y);

    vga_blink_timer #(
        .BLINK_FRAMES    (BLINK_FRAMES),
        .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
    ) u_blink (
        .clk         (clk),
        .rst_n       (rst_n),
        .vsync_in    (vsync_in),
        .blink_phase (blink_phase)
    );

    // S1: issue text RAM address, capture pixel position, cursor match and syncs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            text_addr <= '0;
            vld_pipe  <= '0;
            s1        <= '{px: 3'd0, py: 3'd0, von: 1'b0, hs: SYNC_IDLE, vs: SYNC_IDLE, cur: 1'b0};
        end else begin
            text_addr <= cell_addr;
            vld_pipe  <= {vld_pipe[0], 1'b1};
            s1        <= '{px: h_cnt[2:0], py: v_cnt[2:0], von: video_on,
                           hs: hsync_in, vs: vsync_in, cur: cur_hit};
        end
    end

    assign font_addr = {text_data[CHAR_MSB:CHAR_LSB], s1.py};

    // S2: pick the dot from the font row and latch the cell attributes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2 <= '{dot: 1'b0, fg: 4'h0, bg: 4'h0, blk: 1'b0, cur7: 1'b0,
                    von: 1'b0, hs: SYNC_IDLE, vs: SYNC_IDLE};
        end else begin
            s2 <= '{dot:  font_row[3'd7 - s1.px],
                    fg:   text_data[FG_LSB +: 4],
                    bg:   text_data[BG_LSB +: 4],
                    blk:  text_data[BLINK_BIT],
                    cur7: s1.cur && (s1.py == 3'd7),
                    von:  s1.von,
                    hs:   s1.hs,
                    vs:   s1.vs};
        end
    end

    // Blink-char hides the glyph in the off phase; the cursor underline wins over it
    always_comb begin
        on = s2.dot;
        if (s2.blk && blink_phase)
            on = 1'b0;
        if (s2.cur7 && blink_phase)
            on = 1'b1;
    end

    // S3: colour lookup, blanking, and sync outputs aligned with rgb
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb   <= '0;
            hsync <= SYNC_IDLE;
            vsync <= SYNC_IDLE;
        end else begin
            rgb   <= (vld_pipe[1] && s2.von) ? palette(on ? s2.fg : s2.bg) : 12'h000;
            hsync <= s2.hs;
            vsync <= s2.vs;
        end
    end

endmodule

// File: tb/tb_vga_text_render.sv
// Scoreboarded bench: every driven pixel queues its expected rgb/syncs 3 clocks out.
module tb_vga_text_render;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  h_cnt = '0;
    logic [9:0]  v_cnt = '0;
    logic        video_on = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [12:0] text_addr;
    logic [15:0] text_data;
    logic [9:0]  font_addr;
    logic [7:0]  font_row;
    logic [6:0]  cur_x = '0;
    logic [5:0]  cur_y = '0;
    logic        cur_en = 1'b0;
    logic [11:0] rgb;
    logic        hsync;
    logic        vsync;

    always #5 clk = ~clk;

    vga_text_render #(.BLINK_FRAMES(2), .SYNC_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .text_addr(text_addr),
        .text_data(text_data), .font_addr(font_addr), .font_row(font_row),
        .cur_x(cur_x), .cur_y(cur_y), .cur_en(cur_en), .rgb(rgb),
        .hsync(hsync), .vsync(vsync)
    );

    // Text RAM: address registered by the DUT, data returned in the following cycle
    logic [15:0] tram [0:8191];
    assign text_data = tram[text_addr];

    // Font ROM: 'A' = 8'h18 on rows 0-6, blank on row 7; 7F = solid; others blank
    always_comb begin
        font_row = 8'h00;
        if (font_addr[9:3] == 7'h41)
            font_row = (font_addr[2:0] == 3'd7) ? 8'h00 : 8'h18;
        else if (font_addr[9:3] == 7'h7F)
            font_row = 8'hFF;
    end

    logic [11:0] pal_tab [0:15] = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A,
                                    12'hAA0, 12'hAAA, 12'h555, 12'h00F, 12'h0F0, 12'h0FF,
                                    12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        int          due;
        bit          kill;
        string       name;
    } exp_t;

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        von;
        logic        hs;
        logic [11:0] rgb;
        logic [12:0] addr;
        bit          ca;
        string       name;
    } vec_t;

    exp_t        sb[$];
    vec_t        vt[$];
    int          edges = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [12:0] addr_exp = '0;
    bit          addr_chk = 1'b0;
    string       addr_name = "";

    task automatic tick();
        exp_t r;
        @(posedge clk);
        edges++;
        // Anything in flight across a reset edge comes out as reset values
        if (!rst_n)
            foreach (sb[i]) sb[i].kill = 1'b1;
        @(negedge clk);
        if (addr_chk) begin
            n_chk++;
            if (text_addr !== addr_exp) begin
                n_fail++;
                $display("FAIL addr %s: text_addr got %0d want %0d", addr_name, text_addr, addr_exp);
            end
            addr_chk = 1'b0;
        end
        while (sb.size() > 0 && sb[0].due == edges) begin
            r = sb.pop_front();
            if (r.kill) begin
                r.rgb = 12'h000;
                r.hs  = 1'b1;
                r.vs  = 1'b1;
            end
            n_chk++;
            if (rgb !== r.rgb || hsync !== r.hs || vsync !== r.vs) begin
                n_fail++;
                $display("FAIL %s @%0d: rgb/hs/vs got %h/%b/%b want %h/%b/%b",
                         r.name, edges, rgb, hsync, vsync, r.rgb, r.hs, r.vs);
            end
        end
    endtask

    task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic von,
                         input logic hs, input logic vs, input logic [11:0] e_rgb,
                         input string nm, input logic [12:0] ea, input bit ca);
        exp_t r;
        h_cnt = h; v_cnt = v; video_on = von; hsync_in = hs; vsync_in = vs;
        r.rgb = e_rgb; r.hs = hs; r.vs = vs; r.due = edges + 3; r.kill = 1'b0; r.name = nm;
        sb.push_back(r);
        addr_exp = ea; addr_chk = ca; addr_name = nm;
        tick();
    endtask

    // One vsync pulse wrapped in blanking so no visible pixel straddles a phase change
    task automatic frame_pulse();
        drive(10'd0, 10'd480, 1'b0, 1'b1, 1'b1, 12'h000, "vbl", 13'd0, 1'b0);
        drive(10'd0, 10'd490, 1'b0, 1'b1, 1'b0, 12'h000, "vsync", 13'd0, 1'b0);
        drive(10'd0, 10'd491, 1'b0, 1'b1, 1'b0, 12'h000, "vsync", 13'd0, 1'b0);
        drive(10'd0, 10'd495, 1'b0, 1'b1, 1'b1, 12'h000, "vbl", 13'd0, 1'b0);
        drive(10'd0, 10'd496, 1'b0, 1'b1, 1'b1, 12'h000, "vbl", 13'd0, 1'b0);
    endtask

    initial begin
        int ph;
        for (int i = 0; i < 8192; i++) tram[i] = 16'h0000;
        tram[0]    = 16'h1C00;   // cursor cell: bg 1, fg C, blank glyph
        tram[1]    = 16'h197F;   // solid glyph, fg 9
        tram[2]    = 16'h1900;   // blank glyph, bg 1
        tram[3]    = 16'h8C7F;   // solid glyph, fg C
        tram[4]    = 16'h8C00;   // blank glyph, bg 8
        tram[5]    = 16'h0FFF;   // blinking solid glyph, fg F bg 0
        tram[80]   = 16'h1C00;   // cell reached at column 80 in blanking
        tram[242]  = 16'h0F41;   // 'A' fg F bg 0
        tram[4799] = 16'hFF7F;
        tram[4800] = 16'h1C00;   // cell reached at row 60 in blanking

        vt.push_back('{10'd17,  10'd25,  1'b1, 1'b1, 12'h000, 13'd242,  1'b1, "A_px1"});
        vt.push_back('{10'd19,  10'd25,  1'b1, 1'b1, 12'hFFF, 13'd242,  1'b1, "A_px3"});
        vt.push_back('{10'd20,  10'd25,  1'b1, 1'b1, 12'hFFF, 13'd242,  1'b1, "A_px4"});
        vt.push_back('{10'd16,  10'd25,  1'b1, 1'b1, 12'h000, 13'd242,  1'b1, "A_px0"});
        vt.push_back('{10'd19,  10'd31,  1'b1, 1'b1, 12'h000, 13'd242,  1'b1, "A_row7"});
        vt.push_back('{10'd639, 10'd479, 1'b0, 1'b1, 12'h000, 13'd4799, 1'b1, "last_cell"});
        vt.push_back('{10'd19,  10'd25,  1'b0, 1'b1, 12'h000, 13'd242,  1'b1, "von0"});
        vt.push_back('{10'd8,   10'd0,   1'b1, 1'b1, 12'h00F, 13'd1,    1'b1, "pal9_on"});
        vt.push_back('{10'd16,  10'd0,   1'b1, 1'b1, 12'h00A, 13'd2,    1'b1, "pal1_off"});
        vt.push_back('{10'd24,  10'd0,   1'b1, 1'b0, 12'hF00, 13'd3,    1'b1, "palC_on"});
        vt.push_back('{10'd32,  10'd0,   1'b1, 1'b1, 12'h555, 13'd4,    1'b1, "pal8_off"});
        vt.push_back('{10'd40,  10'd0,   1'b1, 1'b1, 12'hFFF, 13'd5,    1'b1, "blinkchr_ph0"});
        vt.push_back('{10'd700, 10'd25,  1'b0, 1'b0, 12'h000, 13'd327,  1'b1, "hblank"});

        // Reset held with live inputs: outputs stay black/idle, address stays 0
        for (int i = 0; i < 5; i++)
            drive(10'd19, 10'd25, 1'b1, 1'b0, 1'b0, 12'h000, "reset", 13'd0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            drive(10'd19, 10'd25, 1'b1, 1'b1, 1'b1, 12'hFFF, "post_rst", 13'd242, 1'b1);

        foreach (vt[i])
            drive(vt[i].h, vt[i].v, vt[i].von, vt[i].hs, 1'b1, vt[i].rgb, vt[i].name,
                  vt[i].addr, vt[i].ca);

        // Single-cycle hsync pulse must reappear 3 clocks later, one cycle wide
        drive(10'd650, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000, "hs_idle", 13'd0, 1'b0);
        drive(10'd656, 10'd0, 1'b0, 1'b0, 1'b1, 12'h000, "hs_pulse", 13'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            drive(10'd660, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000, "hs_idle", 13'd0, 1'b0);

        // Reset mid-line drops in-flight pixels
        for (int i = 0; i < 3; i++)
            drive(10'd19, 10'd25, 1'b1, 1'b1, 1'b1, 12'hFFF, "pre_midrst", 13'd0, 1'b0);
        rst_n = 1'b0;
        drive(10'd19, 10'd25, 1'b1, 1'b0, 1'b1, 12'hFFF, "midrst", 13'd0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            drive(10'd19, 10'd25, 1'b1, 1'b1, 1'b1, 12'hFFF, "post_midrst", 13'd0, 1'b0);

        // Cursor blink over frames 0..4 with BLINK_FRAMES=2
        cur_en = 1'b1; cur_x = 7'd0; cur_y = 6'd0;
        for (int f = 0; f < 5; f++) begin
            ph = (f / 2) % 2;
            drive(10'd3,  10'd7, 1'b1, 1'b1, 1'b1, (ph != 0) ? 12'hF00 : 12'h00A, "cur_row7", 13'd0, 1'b0);
            drive(10'd3,  10'd3, 1'b1, 1'b1, 1'b1, 12'h00A, "cur_row3", 13'd0, 1'b0);
            drive(10'd6,  10'd0, 1'b1, 1'b1, 1'b1, 12'h00A, "cur_row0", 13'd0, 1'b0);
            drive(10'd40, 10'd0, 1'b1, 1'b1, 1'b1, (ph != 0) ? 12'h000 : 12'hFFF, "blink_char", 13'd0, 1'b0);
            frame_pulse();
        end
        frame_pulse();   // frame 6: phase on again

        drive(10'd3, 10'd7, 1'b1, 1'b1, 1'b1, 12'hF00, "cur_ph1", 13'd0, 1'b0);
        cur_x = 7'd80;
        drive(10'd643, 10'd7, 1'b1, 1'b1, 1'b1, 12'h00A, "cur_x_oob", 13'd80, 1'b1);
        cur_x = 7'd0; cur_y = 6'd60;
        drive(10'd3, 10'd487, 1'b1, 1'b1, 1'b1, 12'h00A, "cur_y_oob", 13'd4800, 1'b1);
        cur_en = 1'b0; video_on = 1'b0;

        for (int i = 0; i < 8 && sb.size() > 0; i++)
            tick();
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d outputs still pending, want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
